// File: rtl/cdr_multichain.sv
// Core data register bank: CHAINS serial chains of LENGTH bits with capture, shift,
// update shadow registers, per-bank bypass flops and a chain-length unload counter.
module cdr_multichain #(
  parameter int CHAINS = 2,
  parameter int LENGTH = 8,
  parameter int CW     = $clog2(LENGTH + 1)
) (
  input  logic                       CLK,
  input  logic                       CoreIN_RESET,
  input  logic                       se,
  input  logic                       ce,
  input  logic                       ue,
  input  logic                       bypass,
  input  logic [CHAINS-1:0]          ScanChainIN,
  output logic [CHAINS-1:0]          ScanChainOut,
  input  logic [CHAINS*LENGTH-1:0]   pi,
  output logic [CHAINS*LENGTH-1:0]   po,
  output logic                       shift_done
);

  logic [CHAINS*LENGTH-1:0] sr;
  logic [CHAINS-1:0]        byp;
  logic [CW-1:0]            cnt;

  always_ff @(posedge CLK) begin
    if (CoreIN_RESET) begin
      sr         <= '0;
      po         <= '0;
      byp        <= '0;
      cnt        <= '0;
      shift_done <= 1'b0;
    end else begin
      // Shadow update samples the pre-edge chain contents, independent of shift/capture.
      if (ue) po <= sr;
      shift_done <= 1'b0;
      if (ce) begin
        sr  <= pi;
        cnt <= '0;
      end else if (se && !bypass) begin
        for (int c = 0; c < CHAINS; c++)
          sr[c*LENGTH +: LENGTH] <= {ScanChainIN[c], sr[c*LENGTH+1 +: LENGTH-1]};
        if (cnt == CW'(LENGTH - 1)) begin
          cnt        <= '0;
          shift_done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (se && bypass) begin
        byp <= ScanChainIN;
      end
    end
  end

  always_comb begin
    ScanChainOut = '0;
    for (int c = 0; c < CHAINS; c++)
      ScanChainOut[c] = bypass ? byp[c] : sr[c*LENGTH];
  end

endmodule
